// File: rtl/display_time_decoder_pkg.sv
// Shared constants, types and helpers for the seven-segment time read-back block.
package display_time_decoder_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned BCD_W  = 4;
   localparam int unsigned DIGITS = 6;
   localparam int unsigned WORD_W = SEG_W * DIGITS;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned OFS_W  = 6;

   // Active-low gfedcba patterns for the decimal digits.
   localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b0011000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STABLE = 2'd1,
      ST_DECODE = 2'd2,
      ST_CHECK  = 2'd3
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_SEG     = 2'b01;
   localparam logic [1:0] ERR_RANGE   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   // Bit offset of each field in decode order: S units, S tens, M units, M tens, H units, H tens.
   localparam logic [OFS_W-1:0] OFS_S_UNITS = 6'd0;
   localparam logic [OFS_W-1:0] OFS_S_TENS  = 6'd7;
   localparam logic [OFS_W-1:0] OFS_M_UNITS = 6'd14;
   localparam logic [OFS_W-1:0] OFS_M_TENS  = 6'd21;
   localparam logic [OFS_W-1:0] OFS_H_UNITS = 6'd28;
   localparam logic [OFS_W-1:0] OFS_H_TENS  = 6'd35;

   // Map a digit index to the LSB of its field in the display word.
   function automatic logic [OFS_W-1:0] field_lsb(input logic [IDX_W-1:0] idx);
      logic [OFS_W-1:0] ofs;
      case (idx)
         3'd0:    ofs = OFS_S_UNITS;
         3'd1:    ofs = OFS_S_TENS;
         3'd2:    ofs = OFS_M_UNITS;
         3'd3:    ofs = OFS_M_TENS;
         3'd4:    ofs = OFS_H_UNITS;
         default: ofs = OFS_H_TENS;
      endcase
      return ofs;
   endfunction

   // tens*10 + units using shifts only.
   function automatic logic [6:0] bcd_pair(input logic [BCD_W-1:0] tens, input logic [BCD_W-1:0] units);
      return (7'(tens) << 3) + (7'(tens) << 1) + 7'(units);
   endfunction

endpackage

// File: rtl/display_time_decoder_seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD digit decoder with legality flag.
module seg7_to_bcd
   import display_time_decoder_pkg::*;
(
   input  logic [SEG_W-1:0] seg_i,
   output logic [BCD_W-1:0] digit_o,
   output logic             legal_o
);

   // Exact-match lookup; anything outside the ten codes is illegal.
   always_comb begin
      digit_o = 4'd0;
      legal_o = 1'b1;
      case (seg_i)
         SEG_0:   digit_o = 4'd0;
         SEG_1:   digit_o = 4'd1;
         SEG_2:   digit_o = 4'd2;
         SEG_3:   digit_o = 4'd3;
         SEG_4:   digit_o = 4'd4;
         SEG_5:   digit_o = 4'd5;
         SEG_6:   digit_o = 4'd6;
         SEG_7:   digit_o = 4'd7;
         SEG_8:   digit_o = 4'd8;
         SEG_9:   digit_o = 4'd9;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/display_time_decoder.sv
// Recovers binary HH:MM:SS from the six-digit seven-segment display word.
module display_time_decoder
   import display_time_decoder_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [WORD_W-1:0] display,
   input  logic              sample_en,
   output logic              busy,
   output logic [4:0]        hr,
   output logic [5:0]        min,
   output logic [5:0]        sec,
   output logic              time_valid,
   output logic              time_error,
   output logic [1:0]        err_code
);

   localparam int unsigned STAB_W = $clog2(STABLE_SAMPLES + 1);
   localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

   state_e                         state_q, state_d;
   logic [WORD_W-1:0]              shadow_q, shadow_d;
   logic [STAB_W-1:0]              stab_q, stab_d;
   logic [TMO_W-1:0]               tmo_q, tmo_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [DIGITS-1:0][BCD_W-1:0]   digits_q, digits_d;
   logic                           seg_err_q, seg_err_d;
   logic                           busy_q, busy_d;
   logic [4:0]                     hr_q, hr_d;
   logic [5:0]                     min_q, min_d;
   logic [5:0]                     sec_q, sec_d;
   logic                           valid_q, valid_d;
   logic                           error_q, error_d;
   logic [1:0]                     err_q, err_d;

   logic [SEG_W-1:0]  field_c;
   logic [BCD_W-1:0]  bcd_c;
   logic              legal_c;
   logic [STAB_W-1:0] stab_inc_c;
   logic [TMO_W-1:0]  tmo_inc_c;
   logic              range_err_c;

   assign field_c    = shadow_q[field_lsb(idx_q) +: SEG_W];
   assign stab_inc_c = stab_q + STAB_W'(1);
   assign tmo_inc_c  = tmo_q + TMO_W'(1);
   assign range_err_c = (digits_q[1] > 4'd5) || (digits_q[3] > 4'd5) ||
                        (digits_q[5] > 4'd2) ||
                        ((digits_q[5] == 4'd2) && (digits_q[4] > 4'd3));

   seg7_to_bcd u_seg7_to_bcd (
      .seg_i   (field_c),
      .digit_o (bcd_c),
      .legal_o (legal_c)
   );

   // Next-state and output logic for the sample/stabilise/decode/check sequence.
   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      stab_d    = stab_q;
      tmo_d     = tmo_q;
      idx_d     = idx_q;
      digits_d  = digits_q;
      seg_err_d = seg_err_q;
      busy_d    = busy_q;
      hr_d      = hr_q;
      min_d     = min_q;
      sec_d     = sec_q;
      err_d     = err_q;
      valid_d   = 1'b0;
      error_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sample_en) begin
               shadow_d = display;
               stab_d   = '0;
               tmo_d    = '0;
               busy_d   = 1'b1;
               state_d  = ST_STABLE;
            end
         end
         ST_STABLE: begin
            tmo_d = tmo_inc_c;
            if (tmo_inc_c == TMO_W'(TIMEOUT_CYCLES)) begin
               error_d = 1'b1;
               err_d   = ERR_TIMEOUT;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (display == shadow_q) begin
               stab_d = stab_inc_c;
               if (stab_inc_c == STAB_W'(STABLE_SAMPLES)) begin
                  idx_d     = '0;
                  seg_err_d = 1'b0;
                  state_d   = ST_DECODE;
               end
            end else begin
               shadow_d = display;
               stab_d   = '0;
            end
         end
         ST_DECODE: begin
            digits_d[idx_q] = bcd_c;
            if (!legal_c) seg_err_d = 1'b1;
            if (idx_q == IDX_W'(DIGITS - 1)) state_d = ST_CHECK;
            else                             idx_d   = idx_q + IDX_W'(1);
         end
         ST_CHECK: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (seg_err_q) begin
               error_d = 1'b1;
               err_d   = ERR_SEG;
            end else if (range_err_c) begin
               error_d = 1'b1;
               err_d   = ERR_RANGE;
            end else begin
               sec_d   = 6'(bcd_pair(digits_q[1], digits_q[0]));
               min_d   = 6'(bcd_pair(digits_q[3], digits_q[2]));
               hr_d    = 5'(bcd_pair(digits_q[5], digits_q[4]));
               err_d   = ERR_NONE;
               valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shadow_q  <= '0;
         stab_q    <= '0;
         tmo_q     <= '0;
         idx_q     <= '0;
         digits_q  <= '0;
         seg_err_q <= 1'b0;
         busy_q    <= 1'b0;
         hr_q      <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         err_q     <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         stab_q    <= stab_d;
         tmo_q     <= tmo_d;
         idx_q     <= idx_d;
         digits_q  <= digits_d;
         seg_err_q <= seg_err_d;
         busy_q    <= busy_d;
         hr_q      <= hr_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         err_q     <= err_d;
      end
   end

   assign busy       = busy_q;
   assign hr         = hr_q;
   assign min        = min_q;
   assign sec        = sec_q;
   assign time_valid = valid_q;
   assign time_error = error_q;
   assign err_code   = err_q;

endmodule

// File: tb/tb_display_time_decoder.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_display_time_decoder;

   localparam int STABLE = 3;
   localparam int TMO    = 255;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [41:0] display = '0;
   logic        sample_en = 1'b0;
   logic        busy;
   logic [4:0]  hr;
   logic [5:0]  min;
   logic [5:0]  sec;
   logic        time_valid;
   logic        time_error;
   logic [1:0]  err_code;

   display_time_decoder #(.STABLE_SAMPLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clock      (clock),
      .reset      (reset),
      .display    (display),
      .sample_en  (sample_en),
      .busy       (busy),
      .hr         (hr),
      .min        (min),
      .sec        (sec),
      .time_valid (time_valid),
      .time_error (time_error),
      .err_code   (err_code)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000011, 7'b1111000, 7'b0000000, 7'b0011000};

   function automatic logic [41:0] enc(input int h, input int m, input int s);
      return {seg_tab[h / 10], seg_tab[h % 10], seg_tab[m / 10], seg_tab[m % 10],
              seg_tab[s / 10], seg_tab[s % 10]};
   endfunction

   // Whole-word interpretation: digit lookup, then range test on the numeric values.
   function automatic void conv(input logic [41:0] w, output int code,
                                output int h, output int m, output int s);
      int d [6];
      bit bad;
      logic [6:0] f;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         f = w[i*7 +: 7];
         d[i] = -1;
         for (int j = 0; j < 10; j++) if (seg_tab[j] == f) d[i] = j;
         if (d[i] < 0) begin bad = 1'b1; d[i] = 0; end
      end
      s = d[1] * 10 + d[0];
      m = d[3] * 10 + d[2];
      h = d[5] * 10 + d[4];
      if (bad) code = 1;
      else if (h > 23 || m > 59 || s > 59) code = 2;
      else code = 0;
   endfunction

   // Behavioural model: result of the settled word appears 7 edges after stability is reached.
   int m_phase = 0, m_run = 0, m_elapsed = 0, m_wait = 0;
   logic [41:0] m_shadow = '0;
   int m_busy = 0, m_hr = 0, m_min = 0, m_sec = 0, m_valid = 0, m_error = 0, m_err = 0;

   always @(posedge clock) begin
      int c, h, m, s;
      m_valid = 0;
      m_error = 0;
      if (reset) begin
         m_phase = 0; m_busy = 0; m_hr = 0; m_min = 0; m_sec = 0; m_err = 0;
      end else if (m_phase == 0) begin
         if (sample_en) begin
            m_shadow = display; m_run = 0; m_elapsed = 0; m_busy = 1; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_elapsed++;
         if (m_elapsed >= TMO) begin
            m_error = 1; m_err = 3; m_busy = 0; m_phase = 0;
         end else if (display == m_shadow) begin
            m_run++;
            if (m_run >= STABLE) begin m_phase = 2; m_wait = 7; end
         end else begin
            m_shadow = display; m_run = 0;
         end
      end else begin
         m_wait--;
         if (m_wait == 0) begin
            conv(m_shadow, c, h, m, s);
            m_busy = 0; m_phase = 0; m_err = c;
            if (c == 0) begin m_valid = 1; m_hr = h; m_min = m; m_sec = s; end
            else m_error = 1;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("busy", int'(busy), m_busy);
         check("hr", int'(hr), m_hr);
         check("min", int'(min), m_min);
         check("sec", int'(sec), m_sec);
         check("time_valid", int'(time_valid), m_valid);
         check("time_error", int'(time_error), m_error);
         check("err_code", int'(err_code), m_err);
         check("pulse_exclusive", int'(time_valid && time_error), 0);
      end
   end

   // Start a conversion on word a; mode 1 alternates a/b, 2 glitches b once, 3 pulses sample_en while busy.
   task automatic run_conv(input logic [41:0] a, input logic [41:0] b, input int mode,
                           output int lat, output int code);
      int n;
      @(negedge clock);
      display = a;
      sample_en = 1'b1;
      @(negedge clock);
      sample_en = 1'b0;
      n = 0;
      lat = -1;
      code = -1;
      while (n < 400) begin
         if (time_valid || time_error) begin lat = n; code = int'(err_code); break; end
         if (mode == 1) display = (n % 2 == 0) ? b : a;
         if (mode == 2) display = (n == 1) ? b : a;
         if (mode == 3) sample_en = (n == 3 || n == 9);
         @(negedge clock);
         n++;
      end
      sample_en = 1'b0;
      display = a;
      if (lat < 0) check("pulse_bound", 0, 1);
   endtask

   function automatic logic [41:0] rand_word();
      logic [41:0] w;
      int r;
      r = int'($urandom_range(9));
      if (r < 6) w = enc(int'($urandom_range(23)), int'($urandom_range(59)), int'($urandom_range(59)));
      else if (r < 8) w = enc(int'($urandom_range(29)), int'($urandom_range(69)), int'($urandom_range(69)));
      else begin
         w = enc(int'($urandom_range(23)), int'($urandom_range(59)), int'($urandom_range(59)));
         w[int'($urandom_range(5)) * 7 +: 7] = 7'($urandom);
      end
      return w;
   endfunction

   initial begin
      int lat, code, p;
      logic [41:0] w;
      @(negedge clock);
      chk_en = 1'b1;
      @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_hr", int'(hr), 0);
      check("rst_err", int'(err_code), 0);
      reset = 1'b0;

      run_conv(enc(12, 34, 56), '0, 0, lat, code);
      check("t1_latency", lat, 10);
      check("t1_code", code, 0);
      check("t1_hr", int'(hr), 12);
      check("t1_min", int'(min), 34);
      check("t1_sec", int'(sec), 56);

      run_conv(enc(23, 59, 59), '0, 0, lat, code);
      check("max_code", code, 0);
      check("max_hr", int'(hr), 23);
      check("max_min", int'(min), 59);
      check("max_sec", int'(sec), 59);
      run_conv(enc(0, 0, 0), '0, 0, lat, code);
      check("zero_valid", int'(time_valid), 1);
      check("zero_hr", int'(hr), 0);

      run_conv(enc(12, 34, 56), '0, 0, lat, code);
      run_conv(enc(24, 0, 0), '0, 0, lat, code);
      check("hr24_code", code, 2);
      check("hr24_hold", int'(hr), 12);
      check("hr24_hold_sec", int'(sec), 56);
      run_conv(enc(9, 60, 0), '0, 0, lat, code);
      check("min60_code", code, 2);

      w = enc(12, 34, 56);
      w[6:0] = 7'b1111111;
      run_conv(w, '0, 0, lat, code);
      check("seg_code", code, 1);
      check("seg_latency", lat, 10);
      check("seg_hold_min", int'(min), 34);

      run_conv(enc(12, 34, 56), enc(12, 34, 57), 1, lat, code);
      check("tmo_code", code, 3);
      check("tmo_latency", lat, 255);

      run_conv(enc(1, 2, 3), enc(1, 2, 4), 2, lat, code);
      check("glitch_latency", lat, 13);
      check("glitch_sec", int'(sec), 3);

      run_conv(enc(4, 5, 6), '0, 3, lat, code);
      check("busy_start_latency", lat, 10);
      p = 0;
      repeat (20) begin @(negedge clock); if (time_valid || time_error) p++; end
      check("ignored_starts", p, 0);

      @(negedge clock);
      display = enc(7, 8, 9);
      sample_en = 1'b1;
      @(negedge clock);
      sample_en = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_hr", int'(hr), 0);
      check("mid_rst_sec", int'(sec), 0);
      reset = 1'b0;
      p = 0;
      repeat (20) begin @(negedge clock); if (time_valid || time_error) p++; end
      check("mid_rst_nopulse", p, 0);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         sample_en = ($urandom_range(7) == 0);
         if ($urandom_range(15) == 0) display = rand_word();
         reset = ($urandom_range(999) == 0);
      end
      reset = 1'b0;
      sample_en = 1'b0;
      repeat (300) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/display_time_decoder.md
Name: display_time_decoder

Overview:
Reads back the 42-bit six-digit seven-segment display word (HH:MM:SS) and recovers the binary hour, minute and second counts. The word is the one driven to the board's hex displays.
- Filters the word for stability before decoding.
- Decodes one digit per cycle.
- Range-checks the result.
- Reports each conversion with a one-cycle valid or error pulse.
Used for display self-check and for loading a displayed time back into timekeeping logic.

Parameters:
STABLE_SAMPLES, 3, consecutive cycles the display word must equal the latched copy before decoding (min 1).
TIMEOUT_CYCLES, 255, maximum cycles spent in stability check before aborting with timeout error.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
display  input  42  segment word, [41:35] H tens, [34:28] H units, [27:21] M tens, [20:14] M units, [13:7] S tens, [6:0] S units; each field gfedcba (bit6=g), active-low
sample_en  input  1  start request, sampled in IDLE only
busy  output  1  conversion in progress
hr  output  5  decoded hours 0..23
min  output  6  decoded minutes 0..59
sec  output  6  decoded seconds 0..59
time_valid  output  1  one-cycle pulse, hr/min/sec updated
time_error  output  1  one-cycle pulse, conversion failed
err_code  output  2  00 none, 01 bad segment pattern, 10 out of range, 11 stability timeout; held until next pulse

Behaviour:
- Reset: state IDLE; busy=0; hr/min/sec=0; time_valid=0; time_error=0; err_code=00; all internal counters cleared. Reset mid-conversion aborts the conversion and emits no pulse.
- Legal patterns, digit=code:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  5=0010010, 6=0000011, 7=1111000, 8=0000000, 9=0011000
  Any other pattern is a segment error.
- States: IDLE, STABLE, DECODE, CHECK.
- IDLE: on an edge with sample_en=1, latch display into shadow, clear stab_cnt and tmo_cnt, and go to STABLE. busy=1 from this edge.
- STABLE: each edge increments tmo_cnt.
  - display==shadow: increment stab_cnt. On the edge where the match count reaches STABLE_SAMPLES, go to DECODE with digit index 0.
  - Mismatch: relatch shadow and clear stab_cnt.
  - tmo_cnt reaching TIMEOUT_CYCLES: go to IDLE, pulse time_error, err_code=11. The timeout check has priority over a simultaneous stability completion.
- DECODE: one shadow field per edge, index 0..5 = S units, S tens, M units, M tens, H units, H tens.
  - The BCD nibble is stored.
  - An illegal pattern sets a sticky seg_err flag; decoding of the remaining digits continues.
  - After index 5, go to CHECK.
- CHECK, single edge:
  - seg_err set: err_code=01.
  - Else range error (S tens>5, M tens>5, H tens>2, or H tens=2 with H units>3): err_code=10.
  - Else load hr/min/sec with tens*10+units, computed as (tens<<3)+(tens<<1)+units and truncated to the output width, err_code=00, pulse time_valid.
  - Error cases pulse time_error instead.
  - Always return to IDLE with busy=0.
- Latency with a stable input: start edge E0 → pulse high in the cycle after edge E0+STABLE_SAMPLES+7 (cycle after E10 by default). busy falls on the same edge the pulse rises.
- hr/min/sec change only on time_valid; an error leaves the previous values held.
- time_valid and time_error are never high together.
- sample_en is ignored while busy. A sample_en on the edge that returns to IDLE is also ignored; the next start needs sample_en in IDLE.

Decomposition:
- Shared package:
  - ten segment code constants
  - state enum
  - err_code constants
  - field offset constants (digit index → bit slice)
- Sub-module seg7_to_bcd: combinational, input 7-bit pattern, outputs 4-bit digit and legal flag. Instantiated once, fed from a mux on digit index.

Test Plan:
- Codes for 12:34:56 held steady, sample_en pulse → time_valid in cycle after E10, hr=12 min=34 sec=56 err_code=00, busy high E0..E10.
- Boundary values: 23:59:59 → 23/59/59 valid; then 00:00:00 → 0/0/0 valid.
- Range error: after a valid 12:34:56, display 24:00:00 → time_error, err_code=10, hr/min/sec stay 12/34/56; 09:60:00 → err_code=10.
- Segment error: seconds units field 1111111 → time_error, err_code=01 after full latency.
- Stability: display alternates 12:34:56/12:34:57 every cycle → time_error with err_code=11 after 255 cycles in STABLE. Single glitch mid-STABLE then steady → valid, latency grows by the number of restarted cycles.
- Reset and ignored starts: reset asserted during DECODE → next cycle busy=0, hr/min/sec=0, no pulse. sample_en pulsed while busy → no extra conversion.
